// File: rtl/vga_fill.sv
// vga_fill: rectangle-fill bus master that writes 4bpp pixels into VRAM through
// the vga slave port. The CPU programs X0/Y0/W/H/COLOR, then starts the engine,
// which walks the clipped rectangle word by word and issues masked 32-bit writes.
// Optional build macro VGA_FILL_RMW_EN: pixel-exact edges using read-modify-write
// on edge words that contain a half-covered byte.
module vga_fill #(
  parameter int unsigned H_PIX      = 424,
  parameter int unsigned V_PIX      = 240,
  parameter int unsigned LINE_WORDS = 53,
  parameter logic [14:0] BASE_ADDR  = 15'd0
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic        wr_en_i,
  input  logic [2:0]  address_in_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        ack_o,
  output logic        m_sel_o,
  output logic        m_wr_en_o,
  output logic [3:0]  m_wr_mask_o,
  output logic [15:0] m_address_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  input  logic        m_ack_i,
  output logic        irq_o
);

`ifdef VGA_FILL_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  localparam logic [10:0] H_LIM    = 11'(H_PIX);
  localparam logic [10:0] V_LIM    = 11'(V_PIX);
  localparam logic [9:0]  X_MAX    = 10'(H_PIX - 1);
  localparam logic [9:0]  Y_MAX    = 10'(V_PIX - 1);
  localparam logic [14:0] ROW_STEP = 15'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, SETUP, RREQ, WREQ, NEXT, DONE} state_t;

  state_t      state_q;
  logic [9:0]  x0_q, y0_q, w_q, h_q;
  logic [3:0]  color_q;
  logic        busy_q, done_q, abort_q;
  logic [9:0]  xs_q, xe_q, ye_q, cur_y_q;
  logic [5:0]  cur_xw_q;
  logic [14:0] row_off_q;

  logic [10:0] sum_x, sum_y;
  logic [9:0]  xe_exact, setup_xs, setup_xe, setup_ye, xe_odd;
  logic        clip_empty;

  logic        last_word, go_done, iss_partial;
  logic [5:0]  iss_xw;
  logic [9:0]  iss_y, iss_xs, iss_xe;
  logic [14:0] iss_row, iss_addr;
  logic [3:0]  iss_mask;
  logic [31:0] fill_data, rd_merged;

  logic        unused_din;
  assign unused_din = ^data_in_i[31:10];

  // Byte b of a word is touched when either of its two pixels lies in [xs..xe];
  // pixels 2k and 2k+1 of the word live in byte 3-k.
  function automatic logic [3:0] byte_mask(input logic [5:0] xw, input logic [9:0] xs,
                                           input logic [9:0] xe);
    logic [9:0] p;
    byte_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      p = {1'b0, xw, 3'b000} + 10'(2 * k);
      if (((p + 10'd1) >= xs) && (p <= xe)) byte_mask[2'(3 - k)] = 1'b1;
    end
  endfunction

  assign fill_data = {8{color_q}};

  // Clip the programmed rectangle against the screen to get the walk bounds.
  always_comb begin
    sum_x      = {1'b0, x0_q} + {1'b0, w_q};
    sum_y      = {1'b0, y0_q} + {1'b0, h_q};
    clip_empty = ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM) ||
                 (w_q == 10'd0) || (h_q == 10'd0);
    xe_exact   = (sum_x > H_LIM) ? X_MAX : (x0_q + w_q - 10'd1);
    setup_ye   = (sum_y > V_LIM) ? Y_MAX : (y0_q + h_q - 10'd1);
    xe_odd     = xe_exact | 10'd1;
    if (RMW_EN) begin
      setup_xs = x0_q;
      setup_xe = xe_exact;
    end else begin
      setup_xs = {x0_q[9:1], 1'b0};
      setup_xe = (xe_odd > X_MAX) ? X_MAX : xe_odd;
    end
  end

  // Pick the word the next request targets: first word from SETUP, successor from NEXT.
  always_comb begin
    last_word = 1'b0;
    iss_xw    = cur_xw_q;
    iss_y     = cur_y_q;
    iss_row   = row_off_q;
    iss_xs    = xs_q;
    iss_xe    = xe_q;
    if (state_q == SETUP) begin
      iss_xw  = setup_xs[8:3];
      iss_y   = y0_q;
      iss_row = {5'b00000, y0_q} * ROW_STEP;
      iss_xs  = setup_xs;
      iss_xe  = setup_xe;
    end else if (cur_xw_q == xe_q[8:3]) begin
      last_word = (cur_y_q == ye_q);
      iss_xw    = xs_q[8:3];
      iss_y     = cur_y_q + 10'd1;
      iss_row   = row_off_q + ROW_STEP;
    end else begin
      iss_xw    = cur_xw_q + 6'd1;
    end
    iss_addr    = BASE_ADDR + iss_row + {9'b0, iss_xw};
    iss_mask    = byte_mask(iss_xw, iss_xs, iss_xe);
    iss_partial = RMW_EN && ((iss_xs[0] && (iss_xs[8:3] == iss_xw)) ||
                             (!iss_xe[0] && (iss_xe[8:3] == iss_xw)));
    go_done     = abort_q || ((state_q == SETUP) ? clip_empty : last_word);
  end

`ifdef VGA_FILL_RMW_EN
  // Pixel n of a word (bits [31-4n -: 4]) is painted when it lies in [xs..xe].
  function automatic logic [7:0] nib_cover(input logic [5:0] xw, input logic [9:0] xs,
                                           input logic [9:0] xe);
    logic [9:0] p;
    nib_cover = 8'h00;
    for (int n = 0; n < 8; n++) begin
      p = {1'b0, xw, 3'b000} + 10'(n);
      nib_cover[n] = (p >= xs) && (p <= xe);
    end
  endfunction

  logic [7:0] cover;

  // Merge the colour into the word just read back, keeping uncovered pixels.
  always_comb begin
    cover     = nib_cover(cur_xw_q, xs_q, xe_q);
    rd_merged = m_data_i;
    for (int n = 0; n < 8; n++) begin
      if (cover[n]) rd_merged[31 - 4 * n -: 4] = color_q;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^m_data_i;
  assign rd_merged = fill_data;
`endif

  // Register slave, status bookkeeping and the fill FSM with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      xs_q        <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      cur_y_q     <= '0;
      cur_xw_q    <= '0;
      row_off_q   <= '0;
      data_out_o  <= '0;
      ack_o       <= 1'b0;
      m_sel_o     <= 1'b0;
      m_wr_en_o   <= 1'b0;
      m_wr_mask_o <= '0;
      m_address_o <= '0;
      m_data_o    <= '0;
      irq_o       <= 1'b0;
    end else begin
      ack_o      <= sel_i;
      irq_o      <= 1'b0;
      data_out_o <= '0;

      if (sel_i) begin
        if (wr_en_i) begin
          if (!busy_q) begin
            case (address_in_i)
              3'd0:    x0_q    <= data_in_i[9:0];
              3'd1:    y0_q    <= data_in_i[9:0];
              3'd2:    w_q     <= data_in_i[9:0];
              3'd3:    h_q     <= data_in_i[9:0];
              3'd4:    color_q <= data_in_i[3:0];
              default: ;
            endcase
          end
          if (address_in_i == 3'd5) begin
            if (data_in_i[1]) begin
              if (busy_q) abort_q <= 1'b1;
            end else if (data_in_i[0] && !busy_q) begin
              busy_q  <= 1'b1;
              state_q <= SETUP;
            end
          end
        end else begin
          case (address_in_i)
            3'd0:    data_out_o <= {22'b0, x0_q};
            3'd1:    data_out_o <= {22'b0, y0_q};
            3'd2:    data_out_o <= {22'b0, w_q};
            3'd3:    data_out_o <= {22'b0, h_q};
            3'd4:    data_out_o <= {28'b0, color_q};
            3'd5: begin
              data_out_o <= {30'b0, done_q, busy_q};
              done_q     <= 1'b0;
            end
            default: data_out_o <= '0;
          endcase
        end
      end

      case (state_q)
        SETUP, NEXT: begin
          if (go_done) begin
            state_q <= DONE;
          end else begin
            xs_q        <= iss_xs;
            xe_q        <= iss_xe;
            ye_q        <= setup_ye;
            cur_xw_q    <= iss_xw;
            cur_y_q     <= iss_y;
            row_off_q   <= iss_row;
            m_address_o <= {1'b0, iss_addr};
            m_wr_mask_o <= iss_mask;
            m_sel_o     <= 1'b1;
            if (iss_partial) begin
              m_wr_en_o <= 1'b0;
              state_q   <= RREQ;
            end else begin
              m_wr_en_o <= 1'b1;
              m_data_o  <= fill_data;
              state_q   <= WREQ;
            end
          end
        end
        RREQ: begin
          if (m_sel_o && m_ack_i) begin
            m_sel_o <= 1'b0;
            if (abort_q) begin
              state_q <= DONE;
            end else begin
              m_wr_en_o <= 1'b1;
              m_data_o  <= rd_merged;
              state_q   <= WREQ;
            end
          end
        end
        WREQ: begin
          if (m_sel_o && m_ack_i) begin
            m_sel_o   <= 1'b0;
            m_wr_en_o <= 1'b0;
            state_q   <= NEXT;
          end else if (!m_sel_o) begin
            m_sel_o <= 1'b1;
          end
        end
        DONE: begin
          irq_o   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill.sv
// tb_vga_fill: directed scoreboard bench for vga_fill. Expected bus transactions
// are queued before each job starts; a bus-slave process acks requests and
// compares each one against the head of the queue.
module tb_vga_fill;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        sel_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [2:0]  address_in_i = 3'd0;
  logic [31:0] data_in_i = 32'd0;
  logic [31:0] data_out_o;
  logic        ack_o;
  logic        m_sel_o;
  logic        m_wr_en_o;
  logic [3:0]  m_wr_mask_o;
  logic [15:0] m_address_o;
  logic [31:0] m_data_o;
  logic [31:0] m_data_i = 32'h12345678;
  logic        m_ack_i = 1'b0;
  logic        irq_o;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];

  int assertions = 0;
  int failures = 0;
  int cyc = 0;
  int irq_count = 0;
  int last_irq_cyc = 0;
  int ack_count = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  vga_fill dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .sel_i        (sel_i),
    .wr_en_i      (wr_en_i),
    .address_in_i (address_in_i),
    .data_in_i    (data_in_i),
    .data_out_o   (data_out_o),
    .ack_o        (ack_o),
    .m_sel_o      (m_sel_o),
    .m_wr_en_o    (m_wr_en_o),
    .m_wr_mask_o  (m_wr_mask_o),
    .m_address_o  (m_address_o),
    .m_data_o     (m_data_o),
    .m_data_i     (m_data_i),
    .m_ack_i      (m_ack_i),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (irq_o) begin
      irq_count++;
      last_irq_cyc = cyc;
    end
  end

  task checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Bus slave and monitor: ack each request after ack_delay cycles and score it.
  always @(negedge clk) begin
    txn_t exp_t;
    if (m_ack_i) begin
      m_ack_i = 1'b0;
    end else if (m_sel_o) begin
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        ack_count++;
        m_ack_i = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("bus_unexpected_req", 64'(sb.size()) + 64'd1, 64'd0);
        end else begin
          exp_t = sb.pop_front();
          if (!exp_t.wr)
            checkOutput("bus_read", {47'b0, m_wr_en_o, m_address_o}, {47'b0, exp_t.wr, exp_t.addr});
          else
            checkOutput("bus_write", {11'b0, m_wr_en_o, m_address_o, m_wr_mask_o, m_data_o},
                        {11'b0, exp_t});
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  task pushWrite(input logic [15:0] addr, input logic [3:0] mask, input logic [31:0] data);
    txn_t t;
    t.wr = 1'b1; t.addr = addr; t.mask = mask; t.data = data;
    sb.push_back(t);
  endtask

  task pushRead(input logic [15:0] addr);
    txn_t t;
    t.wr = 1'b0; t.addr = addr; t.mask = 4'h0; t.data = 32'h0;
    sb.push_back(t);
  endtask

  task regWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel_i = 1'b1; wr_en_i = 1'b1; address_in_i = a; data_in_i = d;
    @(posedge clk);
    #1;
    sel_i = 1'b0; wr_en_i = 1'b0;
    checkOutput("ack_write", {63'b0, ack_o}, 64'd1);
  endtask

  task regRead(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    sel_i = 1'b1; wr_en_i = 1'b0; address_in_i = a;
    @(posedge clk);
    #1;
    sel_i = 1'b0;
    checkOutput("ack_read", {63'b0, ack_o}, 64'd1);
    d = data_out_o;
  endtask

  task applyStimulus(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] w,
                     input logic [9:0] h, input logic [3:0] color, output int start_cyc);
    regWrite(3'd0, {22'b0, x0});
    regWrite(3'd1, {22'b0, y0});
    regWrite(3'd2, {22'b0, w});
    regWrite(3'd3, {22'b0, h});
    regWrite(3'd4, {28'b0, color});
    start_cyc = cyc;
    regWrite(3'd5, 32'd1);
  endtask

  // Wait (bounded) for the completion irq, then check pulse width and status.
  task waitIdle(input string name, input int base_irq, input bit check_sb);
    logic [31:0] st;
    for (int i = 0; i < 30000 && irq_count == base_irq; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({name, "_irq_seen"}, 64'(irq_count - base_irq), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput({name, "_irq_single"}, 64'(irq_count - base_irq), 64'd1);
    regRead(3'd5, st);
    checkOutput({name, "_status_done"}, 64'(st), 64'd2);
    regRead(3'd5, st);
    checkOutput({name, "_status_clear"}, 64'(st), 64'd0);
    if (check_sb) checkOutput({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int sc, base_irq, base_ack, a0;
    bit found;

    #2 reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bus", {38'b0, m_sel_o, m_wr_en_o, m_wr_mask_o, m_address_o, irq_o, ack_o},
                64'd0);
    checkOutput("reset_data", {32'b0, m_data_o}, 64'd0);
    checkOutput("reset_rdata", {32'b0, data_out_o}, 64'd0);
    reset_n_i = 1'b1;
    regRead(3'd0, rd);
    checkOutput("reset_x0", 64'(rd), 64'd0);
    regRead(3'd5, rd);
    checkOutput("reset_status", 64'(rd), 64'd0);

    $display("[TB] full-screen fill");
    for (int i = 0; i < 12720; i++) pushWrite(16'(i), 4'hF, 32'h55555555);
    base_irq = irq_count;
    applyStimulus(10'd0, 10'd0, 10'd424, 10'd240, 4'h5, sc);
    regRead(3'd5, rd);
    checkOutput("full_busy", 64'(rd), 64'd1);
    waitIdle("full", base_irq, 1'b1);

    $display("[TB] single aligned word");
    pushWrite(16'd107, 4'hF, 32'hAAAAAAAA);
    base_irq = irq_count;
    applyStimulus(10'd8, 10'd2, 10'd8, 10'd1, 4'hA, sc);
    waitIdle("aligned", base_irq, 1'b1);

    $display("[TB] interior partial word");
    pushWrite(16'd0, 4'b0110, 32'h33333333);
    base_irq = irq_count;
    applyStimulus(10'd2, 10'd0, 10'd4, 10'd1, 4'h3, sc);
    waitIdle("partial", base_irq, 1'b1);

    $display("[TB] bottom-right clipping");
    pushWrite(16'd12719, 4'b0011, 32'h11111111);
    base_irq = irq_count;
    applyStimulus(10'd420, 10'd239, 10'd16, 10'd5, 4'h1, sc);
    waitIdle("clip", base_irq, 1'b1);

`ifdef VGA_FILL_RMW_EN
    $display("[TB] read-modify-write odd edge");
    pushRead(16'd0);
    pushWrite(16'd0, 4'b0100, 32'h123F5678);
`else
    $display("[TB] odd start rounded to byte");
    pushWrite(16'd0, 4'b0100, 32'hFFFFFFFF);
`endif
    base_irq = irq_count;
    applyStimulus(10'd3, 10'd0, 10'd1, 10'd1, 4'hF, sc);
    waitIdle("odd_edge", base_irq, 1'b1);

    $display("[TB] empty rectangles");
    base_irq = irq_count;
    base_ack = ack_count;
    applyStimulus(10'd10, 10'd10, 10'd0, 10'd5, 4'h2, sc);
    waitIdle("w_zero", base_irq, 1'b1);
    checkOutput("w_zero_latency", 64'((last_irq_cyc - sc) <= 3), 64'd1);
    checkOutput("w_zero_no_bus", 64'(ack_count - base_ack), 64'd0);
    base_irq = irq_count;
    applyStimulus(10'd500, 10'd10, 10'd4, 10'd5, 4'h2, sc);
    waitIdle("x_off", base_irq, 1'b1);
    checkOutput("x_off_latency", 64'((last_irq_cyc - sc) <= 3), 64'd1);
    checkOutput("x_off_no_bus", 64'(ack_count - base_ack), 64'd0);

    $display("[TB] start and abort together");
    base_irq = irq_count;
    regWrite(3'd5, 32'd3);
    repeat (5) @(negedge clk);
    regRead(3'd5, rd);
    checkOutput("start_abort_status", 64'(rd), 64'd0);
    checkOutput("start_abort_no_irq", 64'(irq_count - base_irq), 64'd0);
    checkOutput("start_abort_no_bus", 64'(ack_count - base_ack), 64'd0);

    $display("[TB] abort mid-fill");
    for (int i = 0; i < 106; i++) pushWrite(16'(i), 4'hF, 32'h77777777);
    ack_delay = 4;
    base_irq = irq_count;
    base_ack = ack_count;
    applyStimulus(10'd0, 10'd0, 10'd424, 10'd2, 4'h7, sc);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (ack_count >= base_ack + 3 && m_sel_o && !m_ack_i && wait_cnt == 1) found = 1'b1;
    end
    checkOutput("abort_inflight_found", {63'b0, found}, 64'd1);
    a0 = ack_count;
    regWrite(3'd5, 32'd2);
    regWrite(3'd0, 32'd5);
    waitIdle("abort", base_irq, 1'b0);
    checkOutput("abort_one_more_ack", 64'(ack_count - a0), 64'd1);
    checkOutput("abort_work_left", 64'(sb.size() > 0), 64'd1);
    regRead(3'd0, rd);
    checkOutput("busy_write_ignored", 64'(rd), 64'd0);
    sb.delete();
    ack_delay = 0;

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
